// File: rtl/host_if_master.sv
// Host-side initiator for the FPGA register interface: turns single read/write
// commands into SETEP/SETREG/SETRVAL/RDDATA bus sequences with registered outputs.
module host_if_master #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic        if_clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [15:0] cmd_ep,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [3:0]  state,
  output logic [2:0]  ctl,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  input  logic        rdy
);

  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
  localparam logic [3:0]    RDDATA    = 4'h4;
  localparam logic [2:0]    STROBE_CTL = 3'b010;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, GAP, RD_STROBE, RD_WAIT, RD_GAP, RSP
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [1:0]    phase_q, phase_d;
  logic          gap_q, gap_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          rd_q;
  logic [15:0]   ep_q, addr_q, wdata_q;
  logic [15:0]   rdata_q;
  logic          tmo_q;

  logic          accept;
  logic          rdy_hit;
  logic [15:0]   ep_sel, addr_sel, wdata_sel;

  logic          cmd_ready_d, rsp_valid_d, rsp_timeout_d, data_oe_d;
  logic [15:0]   rsp_rdata_d, data_out_d;
  logic [3:0]    state_d;
  logic [2:0]    ctl_d;

  assign accept  = (fsm_q == IDLE) && cmd_valid && cmd_ready;
  // The device pipeline lags two cycles, so rdy only counts from the second RD_WAIT cycle.
  assign rdy_hit = (cnt_q != '0) && rdy;

  assign ep_sel    = accept ? cmd_ep    : ep_q;
  assign addr_sel  = accept ? cmd_addr  : addr_q;
  assign wdata_sel = accept ? cmd_wdata : wdata_q;

  always_ff @(posedge if_clock) begin
    if (reset) begin
      fsm_q   <= IDLE;
      phase_q <= 2'd0;
      gap_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    phase_d = phase_q;
    gap_d   = 1'b0;
    cnt_d   = '0;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          fsm_d   = SETUP;
          phase_d = 2'd0;
        end
      end
      SETUP:  fsm_d = STROBE;
      STROBE: fsm_d = GAP;
      GAP: begin
        if (gap_q) begin
          if (rd_q && phase_q == 2'd1) begin
            fsm_d = RD_STROBE;
          end else if (!rd_q && phase_q == 2'd2) begin
            fsm_d = RSP;
          end else begin
            fsm_d   = SETUP;
            phase_d = phase_q + 2'd1;
          end
        end else begin
          gap_d = 1'b1;
        end
      end
      RD_STROBE: fsm_d = RD_WAIT;
      RD_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (rdy_hit || cnt_q == LAST_WAIT) begin
          fsm_d = RD_GAP;
        end
      end
      RD_GAP: begin
        if (gap_q) begin
          fsm_d = RSP;
        end else begin
          gap_d = 1'b1;
        end
      end
      RSP:     fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge if_clock) begin
    if (reset) begin
      rd_q    <= 1'b0;
      ep_q    <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      tmo_q   <= 1'b0;
    end else begin
      if (accept) begin
        rd_q    <= cmd_rd;
        ep_q    <= cmd_ep;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        rdata_q <= 16'h0000;
        tmo_q   <= 1'b0;
      end
      if (fsm_q == RD_WAIT && fsm_d == RD_GAP) begin
        rdata_q <= rdy_hit ? data_in : 16'h0000;
        tmo_q   <= !rdy_hit;
      end
    end
  end

  // Outputs are decoded from the next state so the registered bus matches the state being entered.
  always_comb begin
    cmd_ready_d   = (fsm_d == IDLE);
    rsp_valid_d   = (fsm_d == RSP);
    rsp_rdata_d   = rsp_rdata;
    rsp_timeout_d = rsp_timeout;
    state_d       = 4'h0;
    ctl_d         = 3'b000;
    data_out_d    = 16'h0000;
    data_oe_d     = 1'b0;
    if (fsm_d == RSP) begin
      rsp_rdata_d   = rdata_q;
      rsp_timeout_d = tmo_q;
    end
    case (fsm_d)
      SETUP, STROBE: begin
        state_d   = {2'b00, phase_d} + 4'd1;
        data_oe_d = 1'b1;
        ctl_d     = (fsm_d == STROBE) ? STROBE_CTL : 3'b000;
        case (phase_d)
          2'd0:    data_out_d = ep_sel;
          2'd1:    data_out_d = addr_sel;
          default: data_out_d = wdata_sel;
        endcase
      end
      RD_STROBE: begin
        state_d = RDDATA;
        ctl_d   = STROBE_CTL;
      end
      RD_WAIT: state_d = RDDATA;
      default: state_d = 4'h0;
    endcase
  end

  always_ff @(posedge if_clock) begin
    if (reset) begin
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0000;
      rsp_timeout <= 1'b0;
      state       <= 4'h0;
      ctl         <= 3'b000;
      data_out    <= 16'h0000;
      data_oe     <= 1'b0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_timeout <= rsp_timeout_d;
      state       <= state_d;
      ctl         <= ctl_d;
      data_out    <= data_out_d;
      data_oe     <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_host_if_master.sv
// Randomized bench for host_if_master: a cycle-indexed model of each command's
// bus sequence plus a simple device that raises rdy a chosen number of cycles after the read strobe.
module tb_host_if_master;

  localparam int TIMEOUT = 1024;
  localparam int TW      = 11;

  logic        if_clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [15:0] cmd_ep, cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic [3:0]  state;
  logic [2:0]  ctl;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] data_in;
  logic        rdy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] lastRdata;
  logic        lastTmo;
  int          expWaits;

  host_if_master #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .if_clock(if_clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_ep(cmd_ep), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .state(state), .ctl(ctl), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .rdy(rdy)
  );

  always #5 if_clock = ~if_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Issue one command and check every cycle from accept to rsp_valid.
  // d = RD_WAIT cycles before rdy (rdy in cycle 9+d), 0 = never; abortAt = cycle to pulse reset.
  task automatic applyStimulus(input bit rd, input logic [15:0] ep, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] rval, input int d,
                               input bit glitch, input bit hold, input int abortAt);
    int          waits;
    int          w;
    int          last;
    int          p;
    int          s;
    bit          gotData;
    logic [3:0]  eState;
    logic [2:0]  eCtl;
    logic        eOe;
    logic [15:0] eData;
    logic [15:0] vals[3];
    cmd_rd    = rd;
    cmd_ep    = ep;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 50) begin
      @(negedge if_clock);
      waits++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (expWaits >= 0) checkOutput("accept_latency", waits, expWaits);
    vals[0] = ep;
    vals[1] = addr;
    vals[2] = wdata;
    gotData = rd && d != 0 && d <= TIMEOUT;
    w    = gotData ? d : TIMEOUT;
    last = rd ? w + 12 : 13;
    for (int c = 1; c <= last; c++) begin
      @(negedge if_clock);
      if (c == 1 && !hold) begin
        cmd_valid = 1'b0;
        cmd_ep    = 16'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = 16'($urandom);
      end
      eState = 4'h0;
      eCtl   = 3'b000;
      eOe    = 1'b0;
      eData  = 16'h0000;
      if (c <= (rd ? 8 : 12)) begin
        p = (c - 1) / 4;
        s = (c - 1) % 4;
        if (s < 2) begin
          eState = 4'(p + 1);
          eOe    = 1'b1;
          eData  = vals[p];
          eCtl   = (s == 1) ? 3'b010 : 3'b000;
        end
      end else if (rd && c == 9) begin
        eState = 4'h4;
        eCtl   = 3'b010;
      end else if (rd && c <= 9 + w) begin
        eState = 4'h4;
      end
      checkOutput("bus_state", 32'(state), 32'(eState));
      checkOutput("bus_ctl", 32'(ctl), 32'(eCtl));
      checkOutput("bus_oe", 32'(data_oe), 32'(eOe));
      if (eOe) checkOutput("bus_data", 32'(data_out), 32'(eData));
      checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(c == last));
      if (c == last) begin
        lastRdata = gotData ? rval : 16'h0000;
        lastTmo   = rd && !gotData;
      end
      checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(lastRdata));
      checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(lastTmo));
      if (c == abortAt) begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        rdy       = 1'b0;
        @(negedge if_clock);
        checkOutput("abort_state", 32'(state), 32'd0);
        checkOutput("abort_ctl", 32'(ctl), 32'd0);
        checkOutput("abort_oe", 32'(data_oe), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        lastRdata = 16'h0000;
        lastTmo   = 1'b0;
        reset     = 1'b0;
        expWaits  = -1;
        return;
      end
      rdy     = rd && ((d != 0 && c == 9 + d) || (glitch && (c == 9 || c == 10)));
      data_in = (rd && d != 0 && c == 9 + d) ? rval : 16'($urandom);
    end
    rdy      = 1'b0;
    expWaits = 1;
  endtask

  task automatic idleCycles(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge if_clock);
      checkOutput("idle_ready", 32'(cmd_ready), 32'd1);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    if (n > 0) expWaits = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  d;
    int  gap;
    bit  rd;
    bit  hold;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_ep    = 16'h0;
    cmd_addr  = 16'h0;
    cmd_wdata = 16'h0;
    data_in   = 16'h0;
    rdy       = 1'b0;
    lastRdata = 16'h0;
    lastTmo   = 1'b0;
    expWaits  = -1;
    repeat (3) @(negedge if_clock);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_ctl", 32'(ctl), 32'd0);
    checkOutput("reset_oe", 32'(data_oe), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    checkOutput("reset_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_rsp", 32'({rsp_valid, rsp_timeout, rsp_rdata}), 32'd0);
    reset = 1'b0;

    applyStimulus(1'b0, 16'h0003, 16'h0010, 16'hBEEF, 16'h0, 0, 1'b0, 1'b0, 0);
    idleCycles(2);
    applyStimulus(1'b1, 16'h0001, 16'h0005, 16'h0, 16'h1234, 3, 1'b0, 1'b0, 0);
    idleCycles(1);
    applyStimulus(1'b1, 16'h0002, 16'h0007, 16'h0, 16'hAAAA, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 16'h0004, 16'h0020, 16'h5A5A, 16'h0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 16'h0011, 16'h0022, 16'h3333, 16'h0, 0, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 16'h0012, 16'h0023, 16'h0, 16'hC0DE, 2, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 16'h0013, 16'h0024, 16'h4444, 16'h0, 0, 1'b0, 1'b0, 0);
    idleCycles(1);
    applyStimulus(1'b0, 16'h0009, 16'h0030, 16'h7777, 16'h0, 0, 1'b0, 1'b0, 6);
    applyStimulus(1'b0, 16'h000A, 16'h0031, 16'h8888, 16'h0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'h000B, 16'h0032, 16'h0, 16'hF00D, 5, 1'b1, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      gap  = $urandom_range(0, 2);
      rd   = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      d    = $urandom_range(2, 40);
      idleCycles(gap);
      applyStimulus(rd, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    d, 1'($urandom_range(0, 1)), hold, 0);
    end
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
